// File: rtl/chacha_param_loader.sv
// Byte-serial loader for the ChaCha key, nonce and block counter.
// A 48-byte frame is assembled, held with a valid/ack handshake, and the counter advances on request.
module chacha_param_loader #(
    parameter int FRAME_BYTES = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         clear,
    input  logic         params_ack,
    input  logic         ctr_inc,
    output logic [255:0] key,
    output logic [95:0]  nonce,
    output logic [31:0]  counter,
    output logic         params_valid,
    output logic [5:0]   load_idx,
    output logic         ctr_overflow
);

    localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   load_idx_q, load_idx_d;
    logic [3:0]   nonce_slot;
    logic         accept;
    logic [255:0] key_q;
    logic [95:0]  nonce_q;
    logic [31:0]  counter_q;
    logic         ovf_q;

    assign accept     = byte_valid && (state_q == LOAD);
    assign nonce_slot = 4'(load_idx_q - 6'd32);

    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        if (clear) begin
            state_d    = LOAD;
            load_idx_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (load_idx_q == LAST_IDX) begin
                            state_d    = HOLD;
                            load_idx_d = '0;
                        end else begin
                            load_idx_d = load_idx_q + 6'd1;
                        end
                    end
                end
                HOLD: begin
                    if (params_ack) begin
                        state_d    = LOAD;
                        load_idx_d = '0;
                    end
                end
                default: begin
                    state_d    = LOAD;
                    load_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            load_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
        end
    end

    // Counter writes only happen in LOAD and increments only in HOLD, so they never collide.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            key_q     <= '0;
            nonce_q   <= '0;
            counter_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                if (load_idx_q < 6'd32)
                    key_q[{load_idx_q[4:0], 3'b000} +: 8] <= byte_in;
                else if (load_idx_q < 6'd44)
                    nonce_q[{nonce_slot, 3'b000} +: 8] <= byte_in;
                else
                    counter_q[{load_idx_q[1:0], 3'b000} +: 8] <= byte_in;
                if (load_idx_q == 6'd0)
                    ovf_q <= 1'b0;
            end
            if ((state_q == HOLD) && ctr_inc) begin
                counter_q <= counter_q + 32'd1;
                if (&counter_q)
                    ovf_q <= 1'b1;
            end
        end
    end

    assign byte_ready   = (state_q == LOAD);
    assign params_valid = (state_q == HOLD);
    assign load_idx     = load_idx_q;
    assign key          = key_q;
    assign nonce        = nonce_q;
    assign counter      = counter_q;
    assign ctr_overflow = ovf_q;

endmodule

// File: tb/tb_chacha_param_loader.sv
// Bench for chacha_param_loader: randomized frames against a byte-array reference model.
module tb_chacha_param_loader;

    logic         clk = 1'b0;
    logic         rst, byte_valid, clear, params_ack, ctr_inc;
    logic [7:0]   byte_in;
    logic         byte_ready, params_valid, ctr_overflow;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic [5:0]   load_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the frame as plain byte arrays plus a held flag.
    logic [7:0]  m_key[32];
    logic [7:0]  m_nonce[12];
    logic [31:0] m_ctr;
    bit          m_hold, m_ovf;
    int          m_idx;
    logic [7:0]  fb[48];

    always #5 clk = ~clk;

    chacha_param_loader #(.FRAME_BYTES(48)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .clear(clear), .params_ack(params_ack),
        .ctr_inc(ctr_inc), .key(key), .nonce(nonce), .counter(counter),
        .params_valid(params_valid), .load_idx(load_idx), .ctr_overflow(ctr_overflow)
    );

    function automatic logic [255:0] exp_key();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = m_key[k];
        return v;
    endfunction

    function automatic logic [95:0] exp_nonce();
        logic [95:0] v;
        for (int k = 0; k < 12; k++) v[8*k +: 8] = m_nonce[k];
        return v;
    endfunction

    task automatic model_step();
        if (rst || clear) begin
            foreach (m_key[k]) m_key[k] = 8'h00;
            foreach (m_nonce[k]) m_nonce[k] = 8'h00;
            m_ctr = 0; m_ovf = 0; m_hold = 0; m_idx = 0;
        end else if (!m_hold) begin
            if (byte_valid) begin
                if (m_idx == 0) m_ovf = 0;
                if (m_idx < 32) m_key[m_idx] = byte_in;
                else if (m_idx < 44) m_nonce[m_idx-32] = byte_in;
                else m_ctr[8*(m_idx-44) +: 8] = byte_in;
                if (m_idx == 47) begin m_hold = 1; m_idx = 0; end
                else m_idx++;
            end
        end else begin
            if (ctr_inc) begin
                if (m_ctr == 32'hFFFF_FFFF) m_ovf = 1;
                m_ctr = m_ctr + 32'd1;
            end
            if (params_ack) begin m_hold = 0; m_idx = 0; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; clear = 0; params_ack = 0; ctr_inc = 0; byte_valid = 0; byte_in = 8'h00;
    endtask

    task automatic stream_frame(input bit gapped);
        int i = 0;
        for (int c = 0; c < 200 && i < 48; c++) begin
            byte_valid = gapped ? (c % 2 == 0) : 1'b1;
            byte_in    = byte_valid ? fb[i] : 8'($urandom);
            tick();
            if (byte_valid) i++;
        end
        byte_valid = 0;
    endtask

    task automatic do_ack();
        params_ack = 1; tick(); params_ack = 0;
    endtask

    task automatic test_reset();
        quiet(); rst = 1; tick(); tick(); rst = 0;
        n_tests++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", byte_ready); end
        n_tests++; if (params_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", params_valid); end
        n_tests++; if (load_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", load_idx); end
        n_tests++; if ({key, nonce, counter} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", key, nonce, counter); end
        n_tests++; if (ctr_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ctr_overflow); end
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 48; i++) begin
            byte_valid = 1; byte_in = 8'(i);
            tick();
            if (i == 46) begin
                n_tests++; if (params_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0", params_valid); end
            end
            n_tests++; if (load_idx !== 6'(m_idx)) begin n_fail++; $display("FAIL full_idx[%0d]: got %0d want %0d", i, load_idx, m_idx); end
        end
        byte_valid = 0;
        n_tests++; if (params_valid !== 1'b1 || byte_ready !== 1'b0) begin n_fail++; $display("FAIL full_handshake: got valid=%b ready=%b want 1 0", params_valid, byte_ready); end
        n_tests++; if (key[31:0] !== 32'h0302_0100) begin n_fail++; $display("FAIL full_key_lo: got %h want 03020100", key[31:0]); end
        n_tests++; if (nonce[31:0] !== 32'h2322_2120) begin n_fail++; $display("FAIL full_nonce_lo: got %h want 23222120", nonce[31:0]); end
        n_tests++; if (counter !== 32'h2F2E_2D2C) begin n_fail++; $display("FAIL full_counter: got %h want 2f2e2d2c", counter); end
        n_tests++; if (key !== exp_key()) begin n_fail++; $display("FAIL full_key: got %h want %h", key, exp_key()); end
        do_ack();
        n_tests++; if (params_valid !== 1'b0 || byte_ready !== 1'b1) begin n_fail++; $display("FAIL full_ack: got valid=%b ready=%b want 0 1", params_valid, byte_ready); end
    endtask

    task automatic test_gapped();
        int i = 0;
        for (int c = 0; c < 96; c++) begin
            byte_valid = (c % 2 == 0);
            byte_in    = byte_valid ? 8'(i) : 8'($urandom);
            tick();
            if (byte_valid) i++;
            n_tests++; if (load_idx !== 6'(m_idx)) begin n_fail++; $display("FAIL gap_idx[%0d]: got %0d want %0d", c, load_idx, m_idx); end
        end
        byte_valid = 0;
        n_tests++; if (key[31:0] !== 32'h0302_0100 || nonce[31:0] !== 32'h2322_2120 || counter !== 32'h2F2E_2D2C) begin
            n_fail++; $display("FAIL gap_outputs: got %h %h %h want 03020100 23222120 2f2e2d2c", key[31:0], nonce[31:0], counter); end
        n_tests++; if (params_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", params_valid); end
        do_ack();
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            foreach (fb[k]) fb[k] = 8'($urandom);
            for (int c = 0; c < 400 && !m_hold; c++) begin
                byte_valid = 1'($urandom);
                byte_in    = 8'($urandom);
                ctr_inc    = 1'($urandom);
                params_ack = 1'($urandom);
                tick();
                n_tests++; if (load_idx !== 6'(m_idx) || counter !== m_ctr) begin
                    n_fail++; $display("FAIL rand_step: got idx=%0d ctr=%h want idx=%0d ctr=%h", load_idx, counter, m_idx, m_ctr); end
            end
            quiet();
            n_tests++; if (key !== exp_key() || nonce !== exp_nonce()) begin n_fail++; $display("FAIL rand_frame: got %h %h want %h %h", key, nonce, exp_key(), exp_nonce()); end
            n_tests++; if (params_valid !== 1'(m_hold)) begin n_fail++; $display("FAIL rand_valid: got %b want %b", params_valid, m_hold); end
            do_ack();
        end
    endtask

    task automatic test_wrap();
        foreach (fb[k]) fb[k] = (k >= 44) ? 8'hFF : 8'($urandom);
        stream_frame(0);
        n_tests++; if (counter !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_load: got %h want ffffffff", counter); end
        ctr_inc = 1; tick();
        n_tests++; if (counter !== 32'h0 || ctr_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_first: got %h ovf=%b want 00000000 1", counter, ctr_overflow); end
        tick(); ctr_inc = 0;
        n_tests++; if (counter !== 32'h1 || ctr_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_second: got %h ovf=%b want 00000001 1", counter, ctr_overflow); end
        repeat (3) tick();
        do_ack();
        n_tests++; if (ctr_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got %b want 1", ctr_overflow); end
        byte_valid = 1; byte_in = 8'h11; tick(); byte_valid = 0;
        n_tests++; if (ctr_overflow !== 1'b0 || load_idx !== 6'd1) begin n_fail++; $display("FAIL wrap_clear: got ovf=%b idx=%0d want 0 1", ctr_overflow, load_idx); end
        clear = 1; tick(); clear = 0;
    endtask

    task automatic test_ack_inc();
        foreach (fb[k]) fb[k] = 8'($urandom);
        fb[44] = 8'h05; fb[45] = 8'h00; fb[46] = 8'h00; fb[47] = 8'h00;
        stream_frame(1);
        params_ack = 1; ctr_inc = 1; tick(); params_ack = 0; ctr_inc = 0;
        n_tests++; if (counter !== 32'd6) begin n_fail++; $display("FAIL ackinc_counter: got %h want 00000006", counter); end
        n_tests++; if (params_valid !== 1'b0 || byte_ready !== 1'b1) begin n_fail++; $display("FAIL ackinc_state: got valid=%b ready=%b want 0 1", params_valid, byte_ready); end
        byte_valid = 1; byte_in = 8'h3C; tick(); byte_valid = 0;
        n_tests++; if (load_idx !== 6'd1 || key[7:0] !== 8'h3C) begin n_fail++; $display("FAIL ackinc_next: got idx=%0d b=%h want 1 3c", load_idx, key[7:0]); end
        clear = 1; tick(); clear = 0;
    endtask

    task automatic test_abort(input bit use_rst);
        for (int i = 0; i < 20; i++) begin byte_valid = 1; byte_in = 8'($urandom); tick(); end
        byte_in = 8'h55;
        if (use_rst) rst = 1; else clear = 1;
        tick(); rst = 0; clear = 0; byte_valid = 0;
        n_tests++; if (load_idx !== 6'd0 || key !== '0) begin n_fail++; $display("FAIL abort_zero[%0d]: got idx=%0d key=%h want 0 0", use_rst, load_idx, key); end
        foreach (fb[k]) fb[k] = 8'($urandom);
        stream_frame(0);
        n_tests++; if (key !== exp_key() || nonce !== exp_nonce() || counter !== m_ctr) begin
            n_fail++; $display("FAIL abort_reload[%0d]: got %h %h %h want %h %h %h", use_rst, key, nonce, counter, exp_key(), exp_nonce(), m_ctr); end
        n_tests++; if (key[7:0] !== fb[0]) begin n_fail++; $display("FAIL abort_byte0[%0d]: got %h want %h", use_rst, key[7:0], fb[0]); end
        do_ack();
    endtask

    task automatic test_hold_ignored();
        foreach (fb[k]) fb[k] = 8'($urandom);
        stream_frame(0);
        for (int i = 0; i < 10; i++) begin byte_valid = 1; byte_in = 8'hAA; tick(); end
        byte_valid = 0;
        n_tests++; if (key !== exp_key() || nonce !== exp_nonce()) begin n_fail++; $display("FAIL hold_frozen: got %h %h want %h %h", key, nonce, exp_key(), exp_nonce()); end
        n_tests++; if (load_idx !== 6'd0 || params_valid !== 1'b1) begin n_fail++; $display("FAIL hold_idx: got idx=%0d valid=%b want 0 1", load_idx, params_valid); end
        do_ack();
        ctr_inc = 1; tick(); tick(); ctr_inc = 0;
        n_tests++; if (counter !== m_ctr) begin n_fail++; $display("FAIL load_inc_ignored: got %h want %h", counter, m_ctr); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        test_reset();
        test_full_frame();
        test_gapped();
        test_random();
        test_wrap();
        test_ack_inc();
        test_abort(0);
        test_abort(1);
        test_hold_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
